hilf_n_shaper: RTL and testbench

N-channel ISI shaping loop filter. It generalises the fixed 6-input, 1st-order, 4-bit shaper to parametrised channel count and state width, with runtime-selectable 1st/2nd order. It adds saturation detection with a sticky flag, synchronous state flush, and order switching that is safe from glitches. It sits between the up-transition vector generator and the DEM element selector, in the same slot as the existing 1st-order shaper.

---
 rtl/hilf_n_shaper_if.sv | 25 ++
 rtl/hilf_n_shaper.sv | 108 ++++++++++
 tb/tb_hilf_n_shaper.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/hilf_n_shaper_if.sv
// Sample-side bus of the N-channel ISI shaping loop filter.
// The master drives the sample strobe and controls, and the shaper drives the shaped vector and status.
interface hilf_n_shaper_if #(
    parameter int unsigned N = 6,
    parameter int unsigned W = 4
);
    logic             clk_en;
    logic [N-1:0]     st;
    logic             order_sel;
    logic             flush;
    logic             sat_clr;
    logic [N*W-1:0]   sfi;
    logic             order_active;
    logic             sat_flag;

    modport master (
        output clk_en, st, order_sel, flush, sat_clr,
        input  sfi, order_active, sat_flag
    );

    modport slave (
        input  clk_en, st, order_sel, flush, sat_clr,
        output sfi, order_active, sat_flag
    );
endinterface

// File: rtl/hilf_n_shaper.sv
// N-channel 1st/2nd-order ISI shaping loop filter with saturation detection and flush.
// Defining HILF_OUT_REG_EN registers sfi, which adds one sample of latency.
module hilf_n_shaper #(
    parameter int unsigned N = 6,
    parameter int unsigned W = 4
) (
    input  logic            clk,
    input  logic            rst,
    hilf_n_shaper_if.slave  bus
);
    localparam int unsigned SW   = W + 3;
    localparam int unsigned MAXV = (1 << W) - 1;

    logic [N-1:0][W-1:0]   a_q;
    logic [N-1:0][W-1:0]   b_q;
    logic                  order_q;
    logic                  sat_q;

    logic signed [SW-1:0]  sr_c [N];
    logic signed [SW-1:0]  su_c;
    logic [SW-1:0]         d_c  [N];
    logic [N-1:0][W-1:0]   fi_c;
    logic                  hit_c;

    // Per-channel intermediate sum. Widening first means the sum never wraps.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (order_q) begin
                sr_c[i] = (SW'(bus.st[i]) + (SW'(a_q[i]) << 1)) - SW'(b_q[i]);
            end else begin
                sr_c[i] = SW'(bus.st[i]) + SW'(a_q[i]);
            end
        end
    end

    // Signed minimum across channels.
    always_comb begin
        su_c = sr_c[0];
        for (int i = 1; i < N; i++) begin
            if (sr_c[i] < su_c) begin
                su_c = sr_c[i];
            end
        end
    end

    // Normalise to the minimum and clamp to the state range.
    always_comb begin
        hit_c = 1'b0;
        fi_c  = '0;
        for (int i = 0; i < N; i++) begin
            d_c[i] = SW'(sr_c[i] - su_c);
            if (d_c[i] > SW'(MAXV)) begin
                fi_c[i] = W'(MAXV);
                hit_c   = 1'b1;
            end else begin
                fi_c[i] = W'(d_c[i]);
            end
        end
    end

    // Loop state. Flush overrides the strobe and is the only point where the order is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            order_q <= 1'b0;
        end else if (bus.flush) begin
            a_q     <= '0;
            b_q     <= '0;
            order_q <= bus.order_sel;
        end else if (bus.clk_en) begin
            a_q     <= fi_c;
            b_q     <= a_q;
        end
    end

    // Sticky saturation flag. A set in the same cycle as a clear wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (bus.clk_en && !bus.flush && hit_c) begin
            sat_q <= 1'b1;
        end else if (bus.sat_clr) begin
            sat_q <= 1'b0;
        end
    end

`ifdef HILF_OUT_REG_EN
    logic [N-1:0][W-1:0] sfi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sfi_q <= '0;
        end else if (bus.flush) begin
            sfi_q <= '0;
        end else if (bus.clk_en) begin
            sfi_q <= fi_c;
        end
    end

    assign bus.sfi = sfi_q;
`else
    assign bus.sfi = fi_c;
`endif

    assign bus.order_active = order_q;
    assign bus.sat_flag     = sat_q;
endmodule

// File: tb/tb_hilf_n_shaper.sv
// Scoreboard testbench for hilf_n_shaper: an arithmetic reference model checked against directed and random stimulus.
module tb_hilf_n_shaper;
    localparam int unsigned N    = 6;
    localparam int unsigned W    = 4;
    localparam int          MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hilf_n_shaper_if #(.N(N), .W(W)) bus ();

    hilf_n_shaper #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] sfi;
        logic           oa;
        logic           sf;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state, kept as plain integers
    int             ma [N];
    int             mb [N];
    bit             mord;
    bit             msat;
    logic [N*W-1:0] moreg;

    function automatic logic [N*W-1:0] model_fi(input logic [N-1:0] s, output bit hit);
        int sr [N];
        int su;
        int d;
        logic [N*W-1:0] r;
        hit = 1'b0;
        r   = '0;
        for (int i = 0; i < N; i++) begin
            sr[i] = mord ? int'(s[i]) + 2 * ma[i] - mb[i] : int'(s[i]) + ma[i];
        end
        su = sr[0];
        for (int i = 1; i < N; i++) if (sr[i] < su) su = sr[i];
        for (int i = 0; i < N; i++) begin
            d = sr[i] - su;
            if (d > MAXV) begin
                d   = MAXV;
                hit = 1'b1;
            end
            r[i*W +: W] = W'(d);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            ma[i] = 0;
            mb[i] = 0;
        end
        mord  = 1'b0;
        msat  = 1'b0;
        moreg = '0;
    endtask

    // One sample period: drive inputs, record the expected outputs, then advance the model past the next edge
    task automatic step(input bit en, input logic [N-1:0] s, input bit osel, input bit fl, input bit sc);
        logic [N*W-1:0] fi;
        bit   hit;
        exp_t e;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.clk_en    = en;
        bus.st        = s;
        bus.order_sel = osel;
        bus.flush     = fl;
        bus.sat_clr   = sc;
        fi = model_fi(s, hit);
`ifdef HILF_OUT_REG_EN
        e.sfi = moreg;
`else
        e.sfi = fi;
`endif
        e.oa = mord;
        e.sf = msat;
        q.push_back(e);
        if (en && !fl && hit) msat = 1'b1;
        else if (sc)          msat = 1'b0;
        if (fl) begin
            for (int i = 0; i < N; i++) begin
                ma[i] = 0;
                mb[i] = 0;
            end
            mord  = osel;
            moreg = '0;
        end else if (en) begin
            for (int i = 0; i < N; i++) begin
                mb[i] = ma[i];
                ma[i] = int'(fi[i*W +: W]);
            end
            moreg = fi;
        end
    endtask

    // Reset asserted between edges; outputs must clear before the next edge
    task automatic async_reset();
        exp_t e;
        @(posedge clk);
        #3;
        rst        = 1'b1;
        bus.st     = '0;
        bus.clk_en = 1'b0;
        bus.flush  = 1'b0;
        bus.sat_clr = 1'b0;
        model_reset();
        e.sfi = '0;
        e.oa  = 1'b0;
        e.sf  = 1'b0;
        q.push_back(e);
    endtask

    // Monitor: compares away from the active edge whenever an expectation is pending
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (bus.sfi !== e.sfi) begin
                failures++;
                $display("FAIL sfi t=%0t got=%h exp=%h", $time, bus.sfi, e.sfi);
            end
            checks++;
            if (bus.order_active !== e.oa) begin
                failures++;
                $display("FAIL order_active t=%0t got=%b exp=%b", $time, bus.order_active, e.oa);
            end
            checks++;
            if (bus.sat_flag !== e.sf) begin
                failures++;
                $display("FAIL sat_flag t=%0t got=%b exp=%b", $time, bus.sat_flag, e.sf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t pending=%0d", $time, q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.clk_en    = 1'b0;
        bus.st        = '0;
        bus.order_sel = 1'b0;
        bus.flush     = 1'b0;
        bus.sat_clr   = 1'b0;
        model_reset();

        // Reset state, then the basic first-order sequence
        async_reset();
        step(1, 6'b000001, 0, 0, 0);
        step(1, 6'b000000, 0, 0, 0);
        step(1, 6'b111110, 0, 0, 0);
        step(1, 6'b000000, 0, 0, 0);

        // Drive channel 0 into saturation, then clear the sticky flag
        step(1, 6'b000000, 0, 1, 0);
        for (int k = 0; k < 16; k++) step(1, 6'b000001, 0, 0, 0);
        step(1, 6'b000000, 0, 0, 0);
        step(1, 6'b000000, 0, 0, 1);
        step(1, 6'b000000, 0, 0, 0);
        // A set in the same cycle as a clear must win
        step(1, 6'b000001, 0, 0, 1);
        step(1, 6'b000000, 0, 0, 0);

        // Second order, including an order request that is not accompanied by a flush
        step(1, 6'b000000, 1, 1, 1);
        step(1, 6'b000001, 0, 0, 0);
        step(1, 6'b000000, 0, 0, 0);
        step(1, 6'b000000, 0, 0, 0);
        step(1, 6'b000000, 0, 0, 0);
        step(1, 6'b000000, 0, 1, 0);
        step(1, 6'b000000, 0, 0, 0);

        // Strobe low: state holds while st toggles
        step(1, 6'b000101, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, (k % 2) ? 6'b101010 : 6'b010101, 0, 0, 0);
        step(1, 6'b000000, 0, 0, 0);

        // The sample presented on a flush edge is dropped
        step(1, 6'b111111, 0, 1, 0);
        step(1, 6'b000000, 0, 0, 0);

        // Reset asserted mid-sequence
        step(1, 6'b000011, 0, 0, 0);
        step(1, 6'b000001, 0, 0, 0);
        async_reset();
        step(1, 6'b000000, 0, 0, 0);

        // Randomised operation across both orders
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(3, 0) != 0), N'($urandom),
                 1'($urandom), ($urandom_range(19, 0) == 0), ($urandom_range(19, 0) == 0));
            if ($urandom_range(99, 0) == 0) async_reset();
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 8 && q.size() > 0; k++) @(negedge clk);
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
